// File: rtl/pll_lock_monitor.sv
// PLL frequency/lock monitor: counts CLKI cycles over REF_PERIODS reference edges.
// Optional reference-loss watchdog: define PLL_LOCK_MONITOR_REF_LOSS_TIMEOUT_EN.
module pll_lock_monitor #(
   parameter int REF_PERIODS = 16,
   parameter int EXP_COUNT   = 128,
   parameter int TOL         = 2,
   parameter int LOCK_GOOD   = 4,
   parameter int TIMEOUT     = 1024
) (
   input  logic        CLKI,
   input  logic        RST,
   input  logic        REF_IN,
   input  logic        FAULT_CLR,
   output logic        LOCK,
   output logic [15:0] COUNT,
   output logic        COUNT_VLD,
   output logic        FAULT,
   output logic        REF_LOSS
);

   typedef enum logic {WAIT, MEAS} state_t;

   localparam logic [15:0] SAT      = 16'hFFFF;
   localparam logic [15:0] RP_M1    = 16'(REF_PERIODS - 1);
   localparam logic [15:0] GOOD_MAX = 16'(LOCK_GOOD);
   localparam logic [15:0] GOOD_M1  = 16'(LOCK_GOOD - 1);
   localparam logic signed [16:0] EXP_S = 17'(EXP_COUNT);
   localparam logic signed [16:0] TOL_S = 17'(TOL);

   state_t state, state_nxt;

   logic        ref_s1, ref_s2, ref_d, ref_rise;
   logic [15:0] cnt, cnt_nxt;
   logic [15:0] edges, edges_nxt;
   logic [15:0] good_cnt;
   logic [15:0] cap;
   logic        win_end, good, loss_evt;
   logic signed [16:0] diff;

   // Synchronizer carries no reset so a high REF_IN cannot fake an edge.
   always_ff @(posedge CLKI) begin
      ref_s1 <= REF_IN;
      ref_s2 <= ref_s1;
      ref_d  <= ref_s2;
   end

   always_ff @(posedge CLKI) begin
      if (RST) ref_rise <= 1'b0;
      else     ref_rise <= ref_s2 & ~ref_d;
   end

`ifdef PLL_LOCK_MONITOR_REF_LOSS_TIMEOUT_EN
   logic [15:0] idle;

   assign loss_evt = !ref_rise && (idle == 16'(TIMEOUT - 1));

   always_ff @(posedge CLKI) begin
      if (RST) begin
         idle     <= '0;
         REF_LOSS <= 1'b0;
      end else begin
         if (ref_rise)         idle <= '0;
         else if (idle != SAT) idle <= idle + 16'd1;
         if (loss_evt)         REF_LOSS <= 1'b1;
         else if (ref_rise)    REF_LOSS <= 1'b0;
      end
   end
`else
   // Without the watchdog TIMEOUT has no effect and loss never fires.
   assign loss_evt = (TIMEOUT < 0);
   assign REF_LOSS = 1'b0;
`endif

   always_ff @(posedge CLKI) begin
      if (RST) state <= WAIT;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      edges_nxt = edges;
      win_end   = 1'b0;
      cap       = (cnt == SAT) ? SAT : cnt + 16'd1;
      unique case (state)
         WAIT: begin
            if (ref_rise) begin
               cnt_nxt   = '0;
               edges_nxt = '0;
               state_nxt = MEAS;
            end
         end
         MEAS: begin
            cnt_nxt = cap;
            if (ref_rise) begin
               if (edges == RP_M1) begin
                  win_end   = 1'b1;
                  cnt_nxt   = '0;
                  edges_nxt = '0;
               end else begin
                  edges_nxt = edges + 16'd1;
               end
            end
         end
      endcase
      if (loss_evt) state_nxt = WAIT;
   end

   assign diff = $signed({1'b0, cap}) - EXP_S;
   assign good = (cap != SAT) && (diff <= TOL_S) && (diff >= -TOL_S);

   always_ff @(posedge CLKI) begin
      if (RST) begin
         cnt       <= '0;
         edges     <= '0;
         good_cnt  <= '0;
         LOCK      <= 1'b0;
         COUNT     <= '0;
         COUNT_VLD <= 1'b0;
         FAULT     <= 1'b0;
      end else begin
         cnt       <= cnt_nxt;
         edges     <= edges_nxt;
         COUNT_VLD <= win_end;
         if (win_end) COUNT <= cap;
         if (loss_evt) begin
            good_cnt <= '0;
            LOCK     <= 1'b0;
         end else if (win_end && good) begin
            if (good_cnt != GOOD_MAX) good_cnt <= good_cnt + 16'd1;
            if (good_cnt >= GOOD_M1)  LOCK <= 1'b1;
         end else if (win_end) begin
            good_cnt <= '0;
            LOCK     <= 1'b0;
         end
         // A new fault outranks a simultaneous clear.
         if (LOCK && (loss_evt || (win_end && !good))) FAULT <= 1'b1;
         else if (FAULT_CLR)                           FAULT <= 1'b0;
      end
   end

endmodule

// File: tb/tb_pll_lock_monitor.sv
// Bench for pll_lock_monitor: REF_IN is scheduled as per-period CLKI cycle
// counts; a window-level model predicts COUNT, LOCK and FAULT.
module tb_pll_lock_monitor;

   localparam int RP   = 16;
   localparam int EXP  = 128;
   localparam int TOLV = 2;
   localparam int LG   = 4;
   localparam int TMO  = 1024;

   logic        CLKI = 1'b0;
   logic        RST = 1'b1;
   logic        REF_IN = 1'b0;
   logic        FAULT_CLR = 1'b0;
   logic        LOCK, COUNT_VLD, FAULT, REF_LOSS;
   logic [15:0] COUNT;

   int n_cmp = 0;
   int n_bad = 0;

   int per_q[$];
   int win_q[$];
   bit clr_q[$];
   int def_per = 8;
   bit gen_on = 1'b0;
   bit race_next = 1'b0;
   bit started = 1'b0;
   int g_edges = 0;
   int g_sum = 0;
   int g_last_p = 0;
   event rise_ev;

   int m_good = 0;
   int e_count = 0;
   bit m_lock = 1'b0;
   bit m_fault = 1'b0;

   pll_lock_monitor #(
      .REF_PERIODS(RP), .EXP_COUNT(EXP), .TOL(TOLV),
      .LOCK_GOOD(LG), .TIMEOUT(TMO)
   ) dut (
      .CLKI(CLKI), .RST(RST), .REF_IN(REF_IN), .FAULT_CLR(FAULT_CLR),
      .LOCK(LOCK), .COUNT(COUNT), .COUNT_VLD(COUNT_VLD),
      .FAULT(FAULT), .REF_LOSS(REF_LOSS)
   );

   always #5 CLKI = ~CLKI;

   // Window bookkeeping at each reference rise: the window value is the
   // sum of the CLKI periods between its start edge and its end edge.
   function automatic void gen_rise(input int p, output bit fire);
      fire = 1'b0;
`ifdef PLL_LOCK_MONITOR_REF_LOSS_TIMEOUT_EN
      if (g_last_p > TMO) started = 1'b0;
`endif
      if (!started) begin
         started = 1'b1;
         g_edges = 0;
         g_sum   = 0;
      end else begin
         g_edges++;
         if (g_edges == RP) begin
            win_q.push_back(g_sum);
            clr_q.push_back(race_next);
            fire      = race_next;
            race_next = 1'b0;
            g_edges   = 0;
            g_sum     = 0;
         end
      end
      g_sum   += p;
      g_last_p = p;
   endfunction

   function automatic bit model_win();
      int s;
      bit clr, g, set;
      if (win_q.size() == 0) return 1'b0;
      s   = win_q.pop_front();
      clr = clr_q.pop_front();
      e_count = (s > 65535) ? 65535 : s;
      g   = (e_count != 65535) && (e_count >= EXP - TOLV) && (e_count <= EXP + TOLV);
      set = !g && m_lock;
      if (g) begin
         if (m_good < LG) m_good++;
         if (m_good >= LG) m_lock = 1'b1;
      end else begin
         m_good = 0;
         m_lock = 1'b0;
      end
      if (set)      m_fault = 1'b1;
      else if (clr) m_fault = 1'b0;
      return 1'b1;
   endfunction

   task automatic clr_race_pulse();
      repeat (3) @(posedge CLKI);
      @(negedge CLKI);
      FAULT_CLR = 1'b1;
      @(negedge CLKI);
      FAULT_CLR = 1'b0;
   endtask

   initial begin
      wait (gen_on);
      forever begin
         int p;
         bit fire;
         @(negedge CLKI);
         p = (per_q.size() != 0) ? per_q.pop_front() : def_per;
         REF_IN = 1'b1;
         gen_rise(p, fire);
         if (fire) fork clr_race_pulse(); join_none
         -> rise_ev;
         repeat (p / 2) @(negedge CLKI);
         REF_IN = 1'b0;
         repeat (p - p / 2 - 1) @(negedge CLKI);
      end
   end

   task automatic wait_vld(output bit ok, output int cyc);
      ok  = 1'b0;
      cyc = 0;
      for (int i = 1; i <= 3000; i++) begin
         @(negedge CLKI);
         if (COUNT_VLD === 1'b1) begin
            ok  = 1'b1;
            cyc = i;
            return;
         end
      end
   endtask

   task automatic push_win(input int extra);
      for (int i = 0; i < 15; i++) per_q.push_back(i < extra ? 9 : 8);
   endtask

   task automatic test_reset();
      repeat (4) @(negedge CLKI);
      n_cmp++; if (LOCK !== 1'b0) begin n_bad++; $display("FAIL rst_lock got %b want 0", LOCK); end
      n_cmp++; if (COUNT !== 16'd0) begin n_bad++; $display("FAIL rst_count got %0d want 0", COUNT); end
      n_cmp++; if (COUNT_VLD !== 1'b0) begin n_bad++; $display("FAIL rst_vld got %b want 0", COUNT_VLD); end
      n_cmp++; if (FAULT !== 1'b0) begin n_bad++; $display("FAIL rst_fault got %b want 0", FAULT); end
      n_cmp++; if (REF_LOSS !== 1'b0) begin n_bad++; $display("FAIL rst_refloss got %b want 0", REF_LOSS); end
   endtask

   task automatic test_lock_acq();
      bit ok, have;
      int cyc;
      for (int w = 0; w < 5; w++) begin
         wait_vld(ok, cyc);
         have = ok ? model_win() : 1'b0;
         n_cmp++;
         if (!have) begin
            n_bad++; $display("FAIL acq_win%0d no matching window vld=%b", w, ok);
         end else begin
            n_cmp++; if (COUNT !== 16'(e_count)) begin n_bad++; $display("FAIL acq_count%0d got %0d want %0d", w, COUNT, e_count); end
            n_cmp++; if (LOCK !== m_lock) begin n_bad++; $display("FAIL acq_lock%0d got %b want %b", w, LOCK, m_lock); end
            n_cmp++; if (FAULT !== m_fault) begin n_bad++; $display("FAIL acq_fault%0d got %b want %b", w, FAULT, m_fault); end
         end
         if (w == 0) begin
            @(negedge CLKI);
            n_cmp++; if (COUNT_VLD !== 1'b0) begin n_bad++; $display("FAIL acq_pulse got %b want 0", COUNT_VLD); end
         end
      end
   endtask

   task automatic test_lock_loss();
      bit ok, have;
      int cyc;
      for (int w = 0; w < 7; w++) begin
         def_per = (w < 2) ? 9 : 8;
         wait_vld(ok, cyc);
         have = ok ? model_win() : 1'b0;
         n_cmp++;
         if (!have) begin
            n_bad++; $display("FAIL loss_win%0d no matching window vld=%b", w, ok);
         end else begin
            n_cmp++; if (COUNT !== 16'(e_count)) begin n_bad++; $display("FAIL loss_count%0d got %0d want %0d", w, COUNT, e_count); end
            n_cmp++; if (LOCK !== m_lock) begin n_bad++; $display("FAIL loss_lock%0d got %b want %b", w, LOCK, m_lock); end
            n_cmp++; if (FAULT !== m_fault) begin n_bad++; $display("FAIL loss_fault%0d got %b want %b", w, FAULT, m_fault); end
         end
      end
      def_per = 8;
   endtask

   task automatic test_tolerance();
      bit ok, have;
      int cyc;
      for (int w = 0; w < 2; w++) begin
         push_win(w == 0 ? 2 : 3);
         wait_vld(ok, cyc);
         have = ok ? model_win() : 1'b0;
         n_cmp++;
         if (!have) begin
            n_bad++; $display("FAIL tol_win%0d no matching window vld=%b", w, ok);
         end else begin
            n_cmp++; if (COUNT !== 16'(e_count)) begin n_bad++; $display("FAIL tol_count%0d got %0d want %0d", w, COUNT, e_count); end
            n_cmp++; if (LOCK !== m_lock) begin n_bad++; $display("FAIL tol_lock%0d got %b want %b", w, LOCK, m_lock); end
            n_cmp++; if (FAULT !== m_fault) begin n_bad++; $display("FAIL tol_fault%0d got %b want %b", w, FAULT, m_fault); end
         end
      end
   endtask

   task automatic test_fault_clr();
      bit ok, have;
      int cyc;
      for (int w = 0; w < 5; w++) begin
         if (w == 4) begin
            n_cmp++; if (FAULT !== m_fault) begin n_bad++; $display("FAIL clr_pre got %b want %b", FAULT, m_fault); end
            @(negedge CLKI); FAULT_CLR = 1'b1; m_fault = 1'b0;
            @(negedge CLKI); FAULT_CLR = 1'b0;
            n_cmp++; if (FAULT !== 1'b0) begin n_bad++; $display("FAIL clr_alone1 got %b want 0", FAULT); end
            race_next = 1'b1;
            def_per   = 9;
         end
         wait_vld(ok, cyc);
         def_per = 8;
         have = ok ? model_win() : 1'b0;
         n_cmp++;
         if (!have) begin
            n_bad++; $display("FAIL clr_win%0d no matching window vld=%b", w, ok);
         end else begin
            n_cmp++; if (COUNT !== 16'(e_count)) begin n_bad++; $display("FAIL clr_count%0d got %0d want %0d", w, COUNT, e_count); end
            n_cmp++; if (LOCK !== m_lock) begin n_bad++; $display("FAIL clr_lock%0d got %b want %b", w, LOCK, m_lock); end
            n_cmp++; if (FAULT !== m_fault) begin n_bad++; $display("FAIL clr_fault%0d got %b want %b", w, FAULT, m_fault); end
         end
      end
      @(negedge CLKI); FAULT_CLR = 1'b1; m_fault = 1'b0;
      @(negedge CLKI); FAULT_CLR = 1'b0;
      n_cmp++; if (FAULT !== 1'b0) begin n_bad++; $display("FAIL clr_alone2 got %b want 0", FAULT); end
   endtask

   task automatic test_ref_loss();
      bit ok, have, hit;
      int cyc;
      for (int w = 0; w < 9; w++) begin
         if (w == 4) begin
            per_q.push_back(1300);
            hit = 1'b0;
            for (int k = 0; k < 40 && !hit; k++) begin
               @(rise_ev);
               hit = (g_last_p == 1300);
            end
            n_cmp++; if (!hit) begin n_bad++; $display("FAIL refloss_start no long period seen"); end
            repeat (TMO + 3) @(negedge CLKI);
            n_cmp++; if (REF_LOSS !== 1'b0) begin n_bad++; $display("FAIL refloss_early got %b want 0", REF_LOSS); end
            n_cmp++; if (LOCK !== m_lock) begin n_bad++; $display("FAIL refloss_prelock got %b want %b", LOCK, m_lock); end
            @(negedge CLKI);
`ifdef PLL_LOCK_MONITOR_REF_LOSS_TIMEOUT_EN
            m_fault = m_fault | m_lock;
            m_lock  = 1'b0;
            m_good  = 0;
            n_cmp++; if (REF_LOSS !== 1'b1) begin n_bad++; $display("FAIL refloss_set got %b want 1", REF_LOSS); end
`else
            n_cmp++; if (REF_LOSS !== 1'b0) begin n_bad++; $display("FAIL refloss_tied got %b want 0", REF_LOSS); end
`endif
            n_cmp++; if (LOCK !== m_lock) begin n_bad++; $display("FAIL refloss_lock got %b want %b", LOCK, m_lock); end
            n_cmp++; if (FAULT !== m_fault) begin n_bad++; $display("FAIL refloss_fault got %b want %b", FAULT, m_fault); end
            @(rise_ev);
            repeat (5) @(negedge CLKI);
            n_cmp++; if (REF_LOSS !== 1'b0) begin n_bad++; $display("FAIL refloss_clr got %b want 0", REF_LOSS); end
         end
         wait_vld(ok, cyc);
         have = ok ? model_win() : 1'b0;
         n_cmp++;
         if (!have) begin
            n_bad++; $display("FAIL rl_win%0d no matching window vld=%b", w, ok);
         end else begin
            n_cmp++; if (COUNT !== 16'(e_count)) begin n_bad++; $display("FAIL rl_count%0d got %0d want %0d", w, COUNT, e_count); end
            n_cmp++; if (LOCK !== m_lock) begin n_bad++; $display("FAIL rl_lock%0d got %b want %b", w, LOCK, m_lock); end
            n_cmp++; if (FAULT !== m_fault) begin n_bad++; $display("FAIL rl_fault%0d got %b want %b", w, FAULT, m_fault); end
         end
      end
   endtask

   task automatic test_random();
      bit ok, have;
      int cyc;
      for (int w = 0; w < 8; w++) begin
         if ($urandom_range(2, 0) == 0)
            for (int i = 0; i < RP; i++) per_q.push_back(8);
         else
            for (int i = 0; i < RP; i++) per_q.push_back(int'($urandom_range(9, 7)));
         wait_vld(ok, cyc);
         have = ok ? model_win() : 1'b0;
         n_cmp++;
         if (!have) begin
            n_bad++; $display("FAIL rnd_win%0d no matching window vld=%b", w, ok);
         end else begin
            n_cmp++; if (COUNT !== 16'(e_count)) begin n_bad++; $display("FAIL rnd_count%0d got %0d want %0d", w, COUNT, e_count); end
            n_cmp++; if (LOCK !== m_lock) begin n_bad++; $display("FAIL rnd_lock%0d got %b want %b", w, LOCK, m_lock); end
            n_cmp++; if (FAULT !== m_fault) begin n_bad++; $display("FAIL rnd_fault%0d got %b want %b", w, FAULT, m_fault); end
         end
      end
   endtask

   task automatic test_reset_mid();
      bit ok, have, hit;
      int cyc;
      per_q.delete();
      hit = 1'b0;
      for (int k = 0; k < 40 && !hit; k++) begin
         @(rise_ev);
         hit = (g_edges == 8);
      end
      n_cmp++; if (!hit) begin n_bad++; $display("FAIL mid_edge8 not reached"); end
      repeat (4) @(negedge CLKI);
      RST = 1'b1;
      started = 1'b0;
      win_q.delete();
      clr_q.delete();
      m_good = 0; m_lock = 1'b0; m_fault = 1'b0;
      @(negedge CLKI);
      n_cmp++; if (LOCK !== 1'b0) begin n_bad++; $display("FAIL mid_lock got %b want 0", LOCK); end
      n_cmp++; if (COUNT !== 16'd0) begin n_bad++; $display("FAIL mid_count got %0d want 0", COUNT); end
      n_cmp++; if (COUNT_VLD !== 1'b0) begin n_bad++; $display("FAIL mid_vld got %b want 0", COUNT_VLD); end
      n_cmp++; if (FAULT !== 1'b0) begin n_bad++; $display("FAIL mid_fault got %b want 0", FAULT); end
      n_cmp++; if (REF_LOSS !== 1'b0) begin n_bad++; $display("FAIL mid_refloss got %b want 0", REF_LOSS); end
      RST = 1'b0;
      wait_vld(ok, cyc);
      have = ok ? model_win() : 1'b0;
      n_cmp++;
      if (!have) begin
         n_bad++; $display("FAIL mid_win no matching window vld=%b", ok);
      end else begin
         n_cmp++; if (cyc != 3 + RP * 8 + 4) begin n_bad++; $display("FAIL mid_latency got %0d want %0d", cyc, 3 + RP * 8 + 4); end
         n_cmp++; if (COUNT !== 16'(e_count)) begin n_bad++; $display("FAIL mid_count2 got %0d want %0d", COUNT, e_count); end
         n_cmp++; if (LOCK !== m_lock) begin n_bad++; $display("FAIL mid_lock2 got %b want %b", LOCK, m_lock); end
      end
   endtask

   initial begin
      test_reset();
      RST    = 1'b0;
      gen_on = 1'b1;
      test_lock_acq();
      test_lock_loss();
      test_tolerance();
      test_fault_clr();
      test_ref_loss();
      test_random();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #3000000;
      $display("FAIL watchdog expired compared=%0d", n_cmp);
      $fatal(1, "watchdog");
   end

endmodule
